// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - opcodes shared with the ALU, muldiv state encoding and XLEN
package alu_defs;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op >= OP_DIV;
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Magnitude result -> architectural result: sign fixup plus half selection.
  // For divides acc holds {remainder, quotient}; for multiplies the full product.
  function automatic logic [XLEN-1:0] finalize(input logic [4:0] op, input logic neg,
                                              input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   val;
    logic [XLEN-1:0]   res;
    prod = neg ? -acc : acc;
    val  = is_rem(op) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (is_div(op))
      res = neg ? -val : val;
    else if (op == OP_MUL)
      res = prod[XLEN-1:0];
    else
      res = prod[2*XLEN-1:XLEN];
    return res;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring divide
module muldiv_step
  import alu_defs::*;
(
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
  // Divide: acc = {partial remainder, dividend/quotient bits}, shifts left.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rem_sh - {1'b0, operand};
    acc_next = {sum, acc[XLEN-1:1]};
    if (div_mode) begin
      if (!diff[XLEN])
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative M-extension unit with pipeline stall
// Optional MULDIV_FAST_MUL_EN: single-step multiplies bypassing RUN.
module muldiv_sequencer
  import alu_defs::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      select,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [4:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] step_out;

  logic              accept;
  logic              last_step;
  logic              signed1, signed2, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              sel_div, div_zero, div_ovf;
  logic              bypass;
  logic [XLEN-1:0]   bypass_res;
  logic              neg_init;
  logic [XLEN-1:0]   opnd_init;
  logic [2*XLEN-1:0] acc_init;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  muldiv_step u_step (
    .div_mode (is_div(op)),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_out)
  );

  // Accept-time decode: signedness, magnitudes, and the RISC-V corner cases.
  always_comb begin
    accept     = (state != ST_RUN) && start && !abort && is_muldiv(select);
    last_step  = (count == CNT_W'(XLEN - 1));
    signed1    = select inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed2    = select inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    s1         = signed1 && data1[XLEN-1];
    s2         = signed2 && data2[XLEN-1];
    mag1       = s1 ? -data1 : data1;
    mag2       = s2 ? -data2 : data2;
    sel_div    = is_div(select);
    div_zero   = sel_div && (data2 == '0);
    div_ovf    = ((select == OP_DIV) || (select == OP_REM)) &&
                 (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
    bypass     = div_zero || div_ovf;
    bypass_res = '0;
    if (div_zero)
      bypass_res = is_rem(select) ? data1 : '1;
    else if (div_ovf)
      bypass_res = is_rem(select) ? '0 : data1;
    neg_init   = is_rem(select) ? s1 : (s1 ^ s2);
    opnd_init  = sel_div ? mag2 : mag1;
    acc_init   = {{XLEN{1'b0}}, (sel_div ? mag1 : mag2)};
`ifdef MULDIV_FAST_MUL_EN
    fast_prod  = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    if (!sel_div) begin
      bypass     = 1'b1;
      bypass_res = finalize(select, s1 ^ s2, fast_prod);
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)
          state_next = bypass ? ST_DONE : ST_RUN;
        else
          state_next = ST_IDLE;
      end
      ST_RUN:  if (last_step) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
    if (abort)
      state_next = ST_IDLE;
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      op     <= '0;
      neg    <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op    <= select;
        neg   <= neg_init;
        opnd  <= opnd_init;
        acc   <= acc_init;
        count <= '0;
        if (bypass)
          result <= bypass_res;
      end else if (state == ST_RUN && !abort) begin
        acc   <= step_out;
        count <= count + CNT_W'(1);
        if (last_step)
          result <= finalize(op, neg, step_out);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam logic [4:0] T_MUL    = 5'b01011;
  localparam logic [4:0] T_MULH   = 5'b01100;
  localparam logic [4:0] T_MULHSU = 5'b01101;
  localparam logic [4:0] T_MULHU  = 5'b01110;
  localparam logic [4:0] T_DIV    = 5'b01111;
  localparam logic [4:0] T_DIVU   = 5'b10000;
  localparam logic [4:0] T_REM    = 5'b10001;
  localparam logic [4:0] T_REMU   = 5'b10010;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  select;
  logic [31:0] data1, data2;
  logic        abort;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .select (select),
    .data1  (data1),
    .data2  (data2),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for DONE from the current sample point; k=0 is the cycle after accept.
  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_cnt,
                           output bit timeout);
    lat = -1; busy_cnt = 0; timeout = 1'b1; res = 'x;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k; res = result; timeout = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt,
                       output bit timeout);
    select = sel; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(res, lat, busy_cnt, timeout);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; select = '0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic run_table(input string tag, input vec_t vecs[]);
    logic [31:0] res;
    int lat, bcnt;
    bit to;
    foreach (vecs[i]) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat, bcnt, to);
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL %s[%0d] timeout: no DONE within 100 cycles", tag, i);
        continue;
      end
      n_checks++;
      if (res !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL %s[%0d] result: got %h required %h", tag, i, res, vecs[i].exp);
      end
      n_checks++;
      if (lat !== vecs[i].lat) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d required %0d", tag, i, lat, vecs[i].lat);
      end
      n_checks++;
      if (bcnt !== vecs[i].lat) begin
        n_fail++;
        $display("FAIL %s[%0d] busy_cycles: got %0d required %0d", tag, i, bcnt, vecs[i].lat);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[%0d] done_pulse: done=%b busy=%b after DONE cycle, required 0 0", tag, i, done, busy);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[];
    v = new[9];
    v[0] = '{T_DIV,    32'd20,        32'd10,        32'd2,         32};
    v[1] = '{T_DIV,    32'hFFFFFFEC,  32'd3,         32'hFFFFFFFA,  32};
    v[2] = '{T_REM,    32'hFFFFFFEC,  32'd3,         32'hFFFFFFFE,  32};
    v[3] = '{T_MUL,    32'd10,        32'd20,        32'd200,       MUL_LAT};
    v[4] = '{T_MULH,   32'd4,         32'hFFFFFFFF,  32'hFFFFFFFF,  MUL_LAT};
    v[5] = '{T_MULHU,  32'd4,         32'hFFFFFFFF,  32'd3,         MUL_LAT};
    v[6] = '{T_MULHSU, 32'd4,         32'hFFFFFFFF,  32'd3,         MUL_LAT};
    v[7] = '{T_DIVU,   32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  32};
    v[8] = '{T_MUL,    32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  MUL_LAT};
    run_table("arith", v);
  endtask

  task automatic test_special();
    vec_t v[];
    v = new[5];
    v[0] = '{T_DIV,  32'd7,         32'd0,         32'hFFFFFFFF, 0};
    v[1] = '{T_REM,  32'd7,         32'd0,         32'd7,        0};
    v[2] = '{T_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000, 0};
    v[3] = '{T_REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,        0};
    v[4] = '{T_REMU, 32'd9,         32'd0,         32'd9,        0};
    run_table("special", v);
  endtask

  task automatic test_abort();
    logic [31:0] prev, res;
    int lat, bcnt, seen;
    bit to;
    prev = result;
    select = T_DIV; data1 = 32'd20; data2 = 32'd10; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_beats_start: busy=%b done=%b required 0 0", busy, done);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_busy: busy=%b required 1", busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: busy=%b done=%b required 0 0", busy, done);
    end
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d DONE cycles required 0", seen);
    end
    n_checks++;
    if (result !== prev) begin
      n_fail++;
      $display("FAIL abort_result_held: got %h required %h", result, prev);
    end
    do_op(T_DIVU, 32'd100, 32'd7, res, lat, bcnt, to);
    n_checks++;
    if (to || res !== 32'd14 || lat !== 32 || bcnt !== 32) begin
      n_fail++;
      $display("FAIL abort_followup: result=%h lat=%0d busy=%0d timeout=%b required 0000000e 32 32 0", res, lat, bcnt, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bcnt;
    bit to;
    do_op(T_DIVU, 32'd100, 32'd7, res, lat, bcnt, to);
    select = T_REMU; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
    n_checks++;
    if (done !== 1'b1 || result !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_prev_result: done=%b result=%h required 1 0000000e", done, result);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rerun: busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(res, lat, bcnt, to);
    n_checks++;
    if (to || res !== 32'd2 || lat !== 32 || bcnt !== 32) begin
      n_fail++;
      $display("FAIL b2b_remu: result=%h lat=%0d busy=%0d timeout=%b required 00000002 32 32 0", res, lat, bcnt, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored();
    int bad;
    bad = 0;
    select = 5'b00001; data1 = 32'd20; data2 = 32'd10; start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    start = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ignored_select: %0d cycles with busy/done set, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bcnt;
    bit to;
    select = T_DIVU; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b1 || result === 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pre: busy=%b result=%h required busy 1 and nonzero result", busy, result);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b done=%b required 0 0", busy, done);
    end
    do_op(T_MUL, 32'd3, 32'd5, res, lat, bcnt, to);
    n_checks++;
    if (to || res !== 32'd15 || lat !== MUL_LAT) begin
      n_fail++;
      $display("FAIL reset_mid_mul: result=%h lat=%0d timeout=%b required 0000000f %0d 0", res, lat, to, MUL_LAT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_abort();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
